// File: rtl/gsensor_spi_ctrl.sv
// gsensor_spi_ctrl: autonomous SPI master sequencer for the ADXL345 accelerometer.
// After reset it waits a power-up margin and writes POWER_CTL, DATA_FORMAT and
// BW_RATE. It then burst-reads DATAX0..DATAZ1 once per SAMPLE_PERIOD while
// enable is high and presents the signed X/Y/Z samples with a one-cycle strobe.
//
// Ports:
//   clk_clk        system clock
//   reset_reset_n  asynchronous active-low reset
//   enable         sampling allowed while high (ignored during initialisation)
//   gsensor_SCLK   SPI clock, mode 3 (idles high)
//   gsensor_MOSI   master data out, MSB first, changes when SCLK falls
//   gsensor_MISO   slave data in, sampled when SCLK rises
//   gsensor_SS_n   chip select, active low
//   accel_x/y/z    signed samples, {DATAn1, DATAn0}
//   sample_valid   one-cycle pulse when accel_* update
//   init_done      sticky, high once the configuration writes have completed
//   busy           high while a transaction or its trailing guard interval runs
module gsensor_spi_ctrl #(
  parameter int unsigned CLK_DIV       = 25,
  parameter int unsigned SAMPLE_PERIOD = 500000,
  parameter logic [7:0]  PWR_CTL_VAL   = 8'h08,
  parameter logic [7:0]  DATA_FMT_VAL  = 8'h0B,
  parameter logic [7:0]  BW_RATE_VAL   = 8'h0A
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        enable,
  output logic        gsensor_SCLK,
  output logic        gsensor_MOSI,
  input  logic        gsensor_MISO,
  output logic        gsensor_SS_n,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic        sample_valid,
  output logic        init_done,
  output logic        busy
);

  localparam int unsigned INIT_CYC = 16 * CLK_DIV;
  localparam int unsigned CNT_MAX  = (INIT_CYC > SAMPLE_PERIOD) ? INIT_CYC : SAMPLE_PERIOD;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX);
  localparam int unsigned DIV_W    = $clog2(CLK_DIV);

  // Half-period tick numbering inside a transaction: odd ticks up to the last
  // edge are SCLK falls, even ticks are rises; SS_n rises one tick after the
  // last rise and the guard interval occupies the two ticks after that.
  localparam logic [6:0] WR_EDGES = 7'd32;   // 16 SCLK periods
  localparam logic [6:0] RD_EDGES = 7'd112;  // 56 SCLK periods

  typedef enum logic [2:0] {
    S_INIT_WAIT,
    S_CFG,
    S_IDLE,
    S_READ,
    S_UPDATE
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [DIV_W-1:0]   div_cnt;
  logic [6:0]         tick, tick_nxt, last_edge;
  logic [1:0]         cfg_idx, load_idx;
  logic [55:0]        tx_sr, tx_load;
  logic [47:0]        rx_sr;
  logic               tick_fire, xfer_done, xfer_start;

  assign busy = (state == S_CFG) || (state == S_READ);

  always_comb begin
    last_edge = (state == S_READ) ? RD_EDGES : WR_EDGES;
    tick_fire = busy && (div_cnt == DIV_W'(CLK_DIV - 1));
    tick_nxt  = tick + 7'd1;
    xfer_done = tick_fire && (tick_nxt == last_edge + 7'd3);
  end

  always_comb begin
    state_nxt  = state;
    xfer_start = 1'b0;
    load_idx   = cfg_idx;
    case (state)
      S_INIT_WAIT: if (cnt == CNT_W'(INIT_CYC - 1)) begin
        state_nxt  = S_CFG;
        xfer_start = 1'b1;
        load_idx   = 2'd0;
      end
      S_CFG: if (xfer_done) begin
        if (cfg_idx == 2'd2) begin
          state_nxt = S_IDLE;
        end else begin
          xfer_start = 1'b1;
          load_idx   = cfg_idx + 2'd1;
        end
      end
      S_IDLE: if ((cnt == CNT_W'(SAMPLE_PERIOD - 1)) && enable) begin
        state_nxt  = S_READ;
        xfer_start = 1'b1;
      end
      S_READ:   if (xfer_done) state_nxt = S_UPDATE;
      S_UPDATE: state_nxt = S_IDLE;
      default:  state_nxt = S_INIT_WAIT;
    endcase

    if (state_nxt == S_READ) begin
      tx_load = {8'hF2, 48'h0};
    end else begin
      case (load_idx)
        2'd0:    tx_load = {8'h2D, PWR_CTL_VAL,  40'h0};
        2'd1:    tx_load = {8'h31, DATA_FMT_VAL, 40'h0};
        default: tx_load = {8'h2C, BW_RATE_VAL,  40'h0};
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= S_INIT_WAIT;
    else                state <= state_nxt;
  end

  // Period counter is shared with the power-up wait; after initialisation it
  // free-runs from each read start and parks at SAMPLE_PERIOD-1 until enable.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cnt       <= '0;
      cfg_idx   <= '0;
      init_done <= 1'b0;
    end else begin
      if (state == S_INIT_WAIT) begin
        cnt <= (state_nxt == S_CFG) ? '0 : cnt + 1'b1;
      end else if (state == S_CFG) begin
        cnt <= '0;
      end else if (xfer_start) begin
        cnt <= '0;
      end else if (cnt != CNT_W'(SAMPLE_PERIOD - 1)) begin
        cnt <= cnt + 1'b1;
      end
      if (xfer_start && (state_nxt == S_CFG)) cfg_idx <= load_idx;
      if ((state == S_CFG) && (state_nxt == S_IDLE)) init_done <= 1'b1;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      gsensor_SCLK <= 1'b1;
      gsensor_SS_n <= 1'b1;
      gsensor_MOSI <= 1'b0;
      div_cnt      <= '0;
      tick         <= '0;
      tx_sr        <= '0;
      rx_sr        <= '0;
    end else if (xfer_start) begin
      gsensor_SS_n <= 1'b0;
      div_cnt      <= '0;
      tick         <= '0;
      tx_sr        <= tx_load;
    end else if (busy) begin
      if (tick_fire) begin
        div_cnt <= '0;
        tick    <= tick_nxt;
        if (tick_nxt <= last_edge) begin
          if (tick_nxt[0]) begin
            gsensor_SCLK <= 1'b0;
            gsensor_MOSI <= tx_sr[55];
            tx_sr        <= {tx_sr[54:0], 1'b0};
          end else begin
            gsensor_SCLK <= 1'b1;
            // The command byte falls off the top; bytes 1..6 remain.
            rx_sr        <= {rx_sr[46:0], gsensor_MISO};
          end
        end else if (tick_nxt == last_edge + 7'd1) begin
          gsensor_SS_n <= 1'b1;
          gsensor_MOSI <= 1'b0;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      accel_x      <= '0;
      accel_y      <= '0;
      accel_z      <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= (state == S_UPDATE);
      if (state == S_UPDATE) begin
        accel_x <= {rx_sr[39:32], rx_sr[47:40]};
        accel_y <= {rx_sr[23:16], rx_sr[31:24]};
        accel_z <= {rx_sr[7:0],   rx_sr[15:8]};
      end
    end
  end

endmodule

// File: tb/tb_gsensor_spi_ctrl.sv
// Self-checking bench for gsensor_spi_ctrl with CLK_DIV=2, SAMPLE_PERIOD=400.
// A pin-level SPI slave records every transaction (MOSI bits, SCLK rises and
// the bytes it returned); expected samples are assembled from those bytes.
module tb_gsensor_spi_ctrl;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned SP      = 400;

  logic        clk = 1'b0, rst_n = 1'b1, enable = 1'b0, miso = 1'b0;
  logic        sclk, mosi, ss_n, sv, idone, busy;
  logic [15:0] ax, ay, az;

  gsensor_spi_ctrl #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SP)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .enable(enable),
    .gsensor_SCLK(sclk), .gsensor_MOSI(mosi), .gsensor_MISO(miso), .gsensor_SS_n(ss_n),
    .accel_x(ax), .accel_y(ay), .accel_z(az),
    .sample_valid(sv), .init_done(idone), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int compared = 0, mismatched = 0;

  typedef struct {
    logic [55:0] mosi;
    logic [47:0] resp;
    int          rises;
  } xfer_t;

  xfer_t       log_q[$];
  logic [47:0] resp_q[$];
  bit          in_xfer = 1'b0;
  int          cur_rises = 0;
  int unsigned last_valid_cyc = 0;
  int          glitch = 0;

  // SPI slave + transaction recorder. Returns bytes 1..6 of a read from resp_q
  // (random if empty), shifting each bit out when SCLK falls.
  initial begin
    xfer_t       rec;
    logic [55:0] acc;
    logic [47:0] cur_resp;
    int          falls, k, j;
    forever begin
      @(negedge ss_n);
      in_xfer = 1'b1; cur_rises = 0; falls = 0; acc = '0; cur_resp = '0;
      while (1) begin
        @(sclk or ss_n);
        if (ss_n) break;
        if (sclk) begin
          acc = {acc[54:0], mosi};
          cur_rises++;
        end else begin
          falls++;
          k = (falls - 1) / 8;
          j = (falls - 1) % 8;
          if (falls == 9) begin
            if (acc[7:0] == 8'hF2 && resp_q.size() > 0) cur_resp = resp_q.pop_front();
            else cur_resp = {16'($urandom), $urandom};
          end
          miso = (k >= 1 && k <= 6) ? cur_resp[47 - 8*(k-1) - j] : 1'b0;
        end
      end
      rec.mosi = acc; rec.resp = cur_resp; rec.rises = cur_rises;
      log_q.push_back(rec);
      in_xfer = 1'b0;
      miso = 1'b0;
    end
  end

  // accel_* may only change together with sample_valid (or under reset).
  logic [15:0] pax = '0, pay = '0, paz = '0;
  always @(negedge clk) begin
    if (rst_n && !sv && (ax !== pax || ay !== pay || az !== paz)) glitch++;
    pax = ax; pay = ay; paz = az;
  end

  // Reference: sample word `pair` (0=X,1=Y,2=Z) is {b(2p+2), b(2p+1)}.
  function automatic logic [15:0] word_of(input logic [47:0] r, input int unsigned pair);
    logic [7:0] lo, hi;
    lo = r[47 - 16*pair -: 8];
    hi = r[39 - 16*pair -: 8];
    return {hi, lo};
  endfunction

  task automatic test_reset();
    int n;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    compared++; if (sclk !== 1'b1) begin mismatched++; $display("FAIL rst_sclk got %b want 1", sclk); end
    compared++; if (ss_n !== 1'b1) begin mismatched++; $display("FAIL rst_ss_n got %b want 1", ss_n); end
    compared++; if (mosi !== 1'b0) begin mismatched++; $display("FAIL rst_mosi got %b want 0", mosi); end
    compared++; if ({ax, ay, az} !== 48'h0) begin mismatched++; $display("FAIL rst_accel got %h want 0", {ax, ay, az}); end
    compared++; if ({sv, idone, busy} !== 3'b000) begin mismatched++; $display("FAIL rst_flags got %b want 000", {sv, idone, busy}); end
    rst_n = 1'b1;
    n = 0;
    while (ss_n && n < 200) begin @(posedge clk); #1; n++; end
    compared++; if (n != 16*CLK_DIV) begin mismatched++; $display("FAIL init_wait got %0d cycles want %0d", n, 16*CLK_DIV); end
  endtask

  task automatic test_init();
    int base, n, sclk_bad, busy_bad, early;
    logic [15:0] exp_w [3];
    exp_w = '{16'h2D08, 16'h310B, 16'h2C0A};
    base = log_q.size(); n = 0; sclk_bad = 0; busy_bad = 0; early = 0;
    while (log_q.size() < base + 3 && n < 3000) begin
      @(negedge clk); n++;
      if (ss_n && !sclk) sclk_bad++;
      if (!ss_n && !busy) busy_bad++;
      if (idone) early++;
    end
    compared++;
    if (log_q.size() < base + 3) begin
      mismatched++; $display("FAIL cfg_count got %0d want %0d", log_q.size() - base, 3);
      return;
    end
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (log_q[base+i].rises != 16 || log_q[base+i].mosi[15:0] !== exp_w[i]) begin
        mismatched++;
        $display("FAIL cfg_write%0d got %h/%0d rises want %h/16", i, log_q[base+i].mosi[15:0], log_q[base+i].rises, exp_w[i]);
      end
    end
    n = 0;
    while (!idone && n < 3*CLK_DIV + 4) begin
      @(negedge clk); n++;
      if (ss_n && !sclk) sclk_bad++;
    end
    compared++; if (idone !== 1'b1) begin mismatched++; $display("FAIL init_done got %b want 1", idone); end
    compared++; if (early != 0) begin mismatched++; $display("FAIL init_done_early got %0d want 0", early); end
    compared++; if (sclk_bad != 0) begin mismatched++; $display("FAIL sclk_idle got %0d lows want 0", sclk_bad); end
    compared++; if (busy_bad != 0) begin mismatched++; $display("FAIL busy_ss got %0d want 0", busy_bad); end
  endtask

  task automatic test_enable_low();
    int lows, pulses, n;
    lows = 0; pulses = 0;
    repeat (2000) begin
      @(negedge clk);
      if (!ss_n) lows++;
      if (sv) pulses++;
    end
    compared++; if (lows != 0 || pulses != 0) begin mismatched++; $display("FAIL idle_quiet got %0d/%0d want 0/0", lows, pulses); end
    resp_q.push_back(48'h3412_7856_BC9A);
    @(negedge clk); enable = 1'b1;
    n = 0;
    while (ss_n && n < 20) begin @(posedge clk); #1; n++; end
    compared++; if (n < 1 || n > 2) begin mismatched++; $display("FAIL enable_latency got %0d want 1..2", n); end
  endtask

  task automatic test_read_pattern();
    int n;
    n = 0;
    while (!sv && n < 1000) begin @(negedge clk); n++; end
    compared++; if (sv !== 1'b1) begin mismatched++; $display("FAIL read_valid got %b want 1", sv); return; end
    last_valid_cyc = cyc;
    compared++; if (ax !== 16'h1234) begin mismatched++; $display("FAIL pat_x got %h want 1234", ax); end
    compared++; if (ay !== 16'h5678) begin mismatched++; $display("FAIL pat_y got %h want 5678", ay); end
    compared++; if (az !== 16'h9ABC) begin mismatched++; $display("FAIL pat_z got %h want 9abc", az); end
    compared++;
    if (log_q[$].mosi !== {8'hF2, 48'h0} || log_q[$].rises != 56) begin
      mismatched++; $display("FAIL read_cmd got %h/%0d want f2000000000000/56", log_q[$].mosi, log_q[$].rises);
    end
    @(negedge clk);
    compared++; if (sv !== 1'b0) begin mismatched++; $display("FAIL valid_width got %b want 0", sv); end
  endtask

  task automatic test_signed_period();
    int n;
    xfer_t rec;
    resp_q.push_back(48'h0080_FFFF_0100);
    repeat (4) resp_q.push_back({16'($urandom), $urandom});
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (!sv && n < 600) begin @(negedge clk); n++; end
      compared++; if (sv !== 1'b1) begin mismatched++; $display("FAIL period_valid%0d got %b want 1", i, sv); return; end
      compared++;
      if (cyc - last_valid_cyc != SP) begin mismatched++; $display("FAIL period%0d got %0d want %0d", i, cyc - last_valid_cyc, SP); end
      last_valid_cyc = cyc;
      rec = log_q[$];
      if (i == 0) begin
        compared++;
        if ($signed(ax) != -32768 || $signed(ay) != -1 || az !== 16'h0001) begin
          mismatched++; $display("FAIL signed got %h %h %h want 8000 ffff 0001", ax, ay, az);
        end
      end else begin
        compared++;
        if (ax !== word_of(rec.resp, 0) || ay !== word_of(rec.resp, 1) || az !== word_of(rec.resp, 2)) begin
          mismatched++;
          $display("FAIL rand_sample%0d got %h %h %h want %h %h %h", i, ax, ay, az,
                   word_of(rec.resp, 0), word_of(rec.resp, 1), word_of(rec.resp, 2));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_enable_drop();
    int n, lows, pulses;
    xfer_t rec;
    n = 0;
    while (!(in_xfer && cur_rises >= 28) && n < 1000) begin @(negedge clk); n++; end
    compared++; if (!(in_xfer && cur_rises >= 28)) begin mismatched++; $display("FAIL drop_reach got %0d rises want 28", cur_rises); return; end
    enable = 1'b0;
    n = 0;
    while (in_xfer && n < 400) begin @(negedge clk); n++; end
    rec = log_q[$];
    compared++; if (in_xfer || rec.rises != 56) begin mismatched++; $display("FAIL drop_rises got %0d want 56", rec.rises); end
    n = 0;
    while (!sv && n < 50) begin @(negedge clk); n++; end
    compared++;
    if (sv !== 1'b1 || ax !== word_of(rec.resp, 0) || ay !== word_of(rec.resp, 1) || az !== word_of(rec.resp, 2)) begin
      mismatched++;
      $display("FAIL drop_update got %b %h %h %h want 1 %h %h %h", sv, ax, ay, az,
               word_of(rec.resp, 0), word_of(rec.resp, 1), word_of(rec.resp, 2));
    end
    @(negedge clk);
    lows = 0; pulses = 0;
    repeat (1500) begin
      @(negedge clk);
      if (!ss_n) lows++;
      if (sv) pulses++;
    end
    compared++; if (lows != 0 || pulses != 0) begin mismatched++; $display("FAIL drop_quiet got %0d/%0d want 0/0", lows, pulses); end
  endtask

  task automatic test_reset_mid();
    int n, base;
    resp_q.push_back({16'($urandom), $urandom});
    @(negedge clk); enable = 1'b1;
    n = 0;
    while (!(in_xfer && cur_rises >= 20) && n < 200) begin @(negedge clk); n++; end
    compared++; if (!(in_xfer && cur_rises >= 20)) begin mismatched++; $display("FAIL rmid_reach got %0d rises want 20", cur_rises); return; end
    @(negedge clk); #2 rst_n = 1'b0; #1;
    compared++; if (ss_n !== 1'b1 || sclk !== 1'b1) begin mismatched++; $display("FAIL rmid_pins got ss_n=%b sclk=%b want 1 1", ss_n, sclk); end
    compared++; if ({ax, ay, az} !== 48'h0 || idone !== 1'b0) begin mismatched++; $display("FAIL rmid_state got %h %b want 0 0", {ax, ay, az}, idone); end
    repeat (3) @(negedge clk);
    base = log_q.size();
    rst_n = 1'b1;
    n = 0;
    while (log_q.size() <= base && n < 300) begin @(negedge clk); n++; end
    compared++;
    if (log_q.size() <= base) begin
      mismatched++; $display("FAIL rmid_rerun got none want 2d08");
    end else if (log_q[base].mosi[15:0] !== 16'h2D08 || log_q[base].rises != 16) begin
      mismatched++; $display("FAIL rmid_rerun got %h/%0d want 2d08/16", log_q[base].mosi[15:0], log_q[base].rises);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_enable_low();
    test_read_pattern();
    test_signed_period();
    test_enable_drop();
    test_reset_mid();
    compared++; if (glitch != 0) begin mismatched++; $display("FAIL accel_hold got %0d changes want 0", glitch); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/gsensor_spi_ctrl.md
Name: gsensor_spi_ctrl

Overview:
- Autonomous SPI master sequencer for the on-board ADXL345 accelerometer (gsensor_* pins).
- After reset it configures the sensor with three register writes, then periodically burst-reads DATAX0..DATAZ1 and presents signed X/Y/Z samples with a one-cycle valid strobe.
- Sits beside the SoC fabric and drives the gsensor pins directly; it replaces software-driven SPI polling.

Parameters:
- CLK_DIV, 25, clk_clk cycles per SCLK half-period (min 2). 25 gives 1 MHz SCLK at 50 MHz.
- SAMPLE_PERIOD, 500000, clk_clk cycles between read-transaction starts (min 400). 500000 gives 100 Hz at 50 MHz.
- PWR_CTL_VAL, 8'h08, value written to reg 0x2D (measure mode).
- DATA_FMT_VAL, 8'h0B, value written to reg 0x31 (full-res, ±16 g, 4-wire).
- BW_RATE_VAL, 8'h0A, value written to reg 0x2C (100 Hz).

Ports:
- clk_clk  in  1  system clock; the only clock.
- reset_reset_n  in  1  asynchronous active-low reset.
- enable  in  1  level; sampling allowed while high.
- gsensor_SCLK  out  1  SPI clock, mode 3 (idle high).
- gsensor_MOSI  out  1  master data out.
- gsensor_MISO  in  1  slave data in.
- gsensor_SS_n  out  1  chip select, active low.
- accel_x  out  16  signed X, {DATAX1, DATAX0}.
- accel_y  out  16  signed Y.
- accel_z  out  16  signed Z.
- sample_valid  out  1  one-cycle pulse when accel_* update.
- init_done  out  1  high once the configuration writes have completed.
- busy  out  1  high while SS_n is low or the guard interval is running.

Behaviour:
- Reset (async assert, sync release): SCLK=1, SS_n=1, MOSI=0, accel_*=0, sample_valid=0, init_done=0, busy=0. State=INIT_WAIT. All counters 0.
- States: INIT_WAIT → CFG(0..2) → IDLE → READ → UPDATE → IDLE.
- INIT_WAIT: wait 16*CLK_DIV cycles (sensor power-up margin), then enter CFG0. enable is ignored during initialisation.
- CFG k: issue a 2-byte write transaction. Order: {8'h2D, PWR_CTL_VAL}, {8'h31, DATA_FMT_VAL}, {8'h2C, BW_RATE_VAL}. Command byte has bit7=0 (write) and bit6=0.
- After CFG2 completes: init_done=1 (sticky until reset), enter IDLE, and start the period counter.
- IDLE: the period counter counts clk_clk cycles. When it reaches SAMPLE_PERIOD-1 and enable=1, reload it and enter READ. If enable=0, hold the counter at SAMPLE_PERIOD-1, so a read starts the cycle after enable rises.
- READ: 7-byte transaction. Command byte is 8'hF2 (R=1, MB=1, addr 0x32), followed by 6 dummy bytes with MOSI=0. Received bytes 1..6 are shifted into a 48-bit buffer.
- UPDATE: one cycle.
  - accel_x={b2,b1}, accel_y={b4,b3}, accel_z={b6,b5}, where bN is the Nth received byte.
  - sample_valid=1 in the same cycle the outputs change.
  - Then return to IDLE.
- Transaction timing (all states that issue a transaction):
  - SS_n falls; CLK_DIV cycles later the first SCLK fall occurs.
  - MOSI changes on the cycle SCLK falls, MSB first. MISO is sampled on the cycle SCLK rises.
  - 8 bits per byte; bytes are back-to-back with no gap.
  - After the final rising edge, SS_n rises CLK_DIV cycles later.
  - Guard interval: SS_n stays high for at least 2*CLK_DIV cycles before the next transaction. busy stays 1 through the guard.
- Transaction length: write = 16 SCLK periods; read = 56 SCLK periods.
- enable falling mid-READ: the transaction completes and UPDATE still happens. There is no abort.
- accel_* hold their values between updates. Partial data is never exposed.
- Reset asserted mid-transaction: pins return to idle immediately (SS_n=1, SCLK=1), and the full INIT sequence reruns after release.

Test Plan:
- Reset release, CLK_DIV=2 → SS_n low after 32 cycles. The three MOSI byte pairs decode as 2D 08, 31 0B, 2C 0A. init_done rises after the third SS_n rise, and SCLK idles high between transactions.
- enable=1, SAMPLE_PERIOD=400, slave model returns 34 12 78 56 BC 9A → MOSI command F2. One cycle after UPDATE: accel_x=0x1234, accel_y=0x5678, accel_z=0x9ABC, with sample_valid high for exactly one cycle.
- Slave returns 00 80 FF FF 01 00 → accel_x=0x8000 (−32768), accel_y=0xFFFF (−1), accel_z=0x0001. Successive sample_valid pulses are spaced exactly 400 cycles apart.
- enable=0 after init → no SS_n activity for 2000 cycles. After enable rises, SS_n falls within 2 cycles.
- Drop enable in the middle of the 4th read byte → the transaction still completes with 56 SCLK rises, accel_* update, and no further reads occur.
- Assert reset_reset_n=0 during the 3rd read byte → SS_n and SCLK go high asynchronously, accel_*=0 and init_done=0. After release, the write sequence 2D 08 repeats.
